// File: rtl/fpu_pkg.sv
// Shared FPU constants and IEEE-754 single-precision field helpers (used by adder and multiplier).
// Latency: n/a (package, combinational helpers only).
// Backpressure: n/a.
package fpu_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EMAX   = 255;
    localparam int MUL_STEPS = 24;

    function automatic logic fp_sign(input logic [31:0] v);
        return v[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] v);
        return v[30:23];
    endfunction

    function automatic logic [22:0] fp_man(input logic [31:0] v);
        return v[22:0];
    endfunction

endpackage

// File: rtl/fp_multiplier_if.sv
// Operand/result bundle between the core (master) and the multiplier (slave).
// Latency: n/a (wires only).
// Backpressure: stall is the only flow control; the master holds run, x, y until stall falls.
// Ports: run (request), x/y (operands), stall (busy), z (registered product).
interface fp_multiplier_if;
    logic        run;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] z;

    modport master (output run, x, y, input stall, z);
    modport slave  (input run, x, y, output stall, z);
endinterface

// File: rtl/fp_pack.sv
// Packs sign/exponent/mantissa into IEEE single, with optional rounding and overflow/underflow clamp.
// Latency: 0 (combinational).
// Backpressure: none.
// Ports: sign, e (10-bit signed exponent), mant ({1,frac}), guard, zero -> z.
// Build option: FPMUL_ROUND_EN defined selects round half-up using guard; otherwise truncate.
module fp_pack
    import fpu_pkg::*;
(
    input  logic        sign,
    input  logic [9:0]  e,
    input  logic [23:0] mant,
    input  logic        guard,
    input  logic        zero,
    output logic [31:0] z
);

`ifdef FPMUL_ROUND_EN
    localparam bit RoundEn = 1'b1;
`else
    localparam bit RoundEn = 1'b0;
`endif

    logic [24:0] sum;
    logic [22:0] frac;
    logic [9:0]  e_r;

    always_comb begin
        sum  = {1'b0, mant} + {24'h0, guard & RoundEn};
        // Carry-out means the rounded significand reached 2.0: fraction wraps to 0, exponent bumps.
        frac = sum[24] ? 23'h0 : sum[22:0];
        e_r  = e + {9'h0, sum[24]};

        if (zero) begin
            z = 32'h0;
        end else if (e_r[9] || (e_r == 10'h0)) begin
            z = 32'h0;
        end else if (e_r >= 10'(FP_EMAX)) begin
            z = {sign, 8'hFF, 23'h0};
        end else begin
            z = {sign, e_r[7:0], frac};
        end
    end

endmodule

// File: rtl/fp_multiplier.sv
// Iterative IEEE single multiplier: 24-step shift-add mantissa product, normalise, pack, register.
// Latency: 26 cycles of stall from run rising; z valid on the first cycle with run & ~stall.
// Backpressure: stall = run & (s != 26); dropping run aborts and leaves z unchanged.
// Ports: clk, rst (async active-high), bus (fp_multiplier_if.slave: run, x, y, stall, z).
// Build option: FPMUL_ROUND_EN (see fp_pack) enables round half-up.
module fp_multiplier
    import fpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    fp_multiplier_if.slave        bus
);

    localparam logic [4:0] SLast = 5'(MUL_STEPS + 1);  // product complete, load Z
    localparam logic [4:0] SDone = 5'(MUL_STEPS + 2);  // result held, stall released

    logic [4:0]  s;
    logic [47:0] p;
    logic [31:0] zr;

    logic [24:0] w;
    logic [9:0]  e;
    logic [23:0] mant;
    logic        guard;
    logic        zero;
    logic        sign;
    logic [31:0] result;

    // One shift-add step: conditionally add the multiplier mantissa to the upper half.
    always_comb begin
        w = {1'b0, p[47:24]} + (p[0] ? {1'b0, 1'b1, fp_man(bus.y)} : 25'h0);
    end

    // Normalise: a product in [2,4) sets p[47] and takes one extra exponent.
    always_comb begin
        sign  = fp_sign(bus.x) ^ fp_sign(bus.y);
        zero  = (fp_exp(bus.x) == 8'h0) || (fp_exp(bus.y) == 8'h0);
        e     = {2'b0, fp_exp(bus.x)} + {2'b0, fp_exp(bus.y)} - 10'(FP_BIAS) + {9'h0, p[47]};
        mant  = p[47] ? {1'b1, p[46:24]} : {1'b1, p[45:23]};
        guard = p[47] ? p[23] : p[22];
    end

    fp_pack u_pack (
        .sign  (sign),
        .e     (e),
        .mant  (mant),
        .guard (guard),
        .zero  (zero),
        .z     (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s  <= 5'h0;
            p  <= 48'h0;
            zr <= 32'h0;
        end else begin
            if (bus.run) begin
                s <= (s == SDone) ? SDone : s + 5'h1;
            end else begin
                s <= 5'h0;
            end

            if (s == 5'h0) begin
                p <= {24'h0, 1'b1, fp_man(bus.x)};
            end else if (s <= 5'(MUL_STEPS)) begin
                p <= {w, p[23:1]};
            end

            if ((s == SLast) && bus.run) begin
                zr <= result;
            end
        end
    end

    assign bus.stall = bus.run && (s != SDone);
    assign bus.z     = zr;

endmodule
